// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared ALU. A granted request is
// executed for one cycle; the captured result is then held until its owner takes it.
module alu_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_op,
    input  logic [63:0] req_in1,
    input  logic [63:0] req_in2,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_out,
    output logic        rsp_zero,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_zero
);

    localparam int unsigned N_REQ  = 2;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [N_REQ-1:0]   grant_c;
    logic               gnt_idx;
    logic               accept;
    logic               capture;
    logic               rsp_done;

    logic               owner_q;
    logic               last_q;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  in1_q;
    logic [DATA_W-1:0]  in2_q;

    logic [OP_W-1:0]    sel_op;
    logic [DATA_W-1:0]  sel_in1;
    logic [DATA_W-1:0]  sel_in2;

    logic [N_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]  rsp_out_q;
    logic               rsp_zero_q;

    // Grant: a lone requester always wins; on contention last_q names the previous winner.
    always_comb begin
        grant_c = '0;
        case (req_valid)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = ((RR_EN != 0) && !last_q) ? 2'b10 : 2'b01;
            default: grant_c = '0;
        endcase
    end

    assign gnt_idx = grant_c[1];

    // Payload of the granted requester.
    always_comb begin
        sel_op  = gnt_idx ? req_op[2*OP_W-1:OP_W]       : req_op[OP_W-1:0];
        sel_in1 = gnt_idx ? req_in1[2*DATA_W-1:DATA_W]  : req_in1[DATA_W-1:0];
        sel_in2 = gnt_idx ? req_in2[2*DATA_W-1:DATA_W]  : req_in2[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant_c;
                if (|(req_valid & grant_c)) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers are the only source of the ALU inputs, so they stay put outside EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else if (accept) begin
            op_q    <= sel_op;
            in1_q   <= sel_in1;
            in2_q   <= sel_in2;
            owner_q <= gnt_idx;
            last_q  <= gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_out_q   <= '0;
            rsp_zero_q  <= 1'b0;
        end else if (capture) begin
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            rsp_out_q   <= alu_out;
            rsp_zero_q  <= alu_zero;
        end else if (rsp_done) begin
            rsp_valid_q <= '0;
        end
    end

    assign alu_op    = op_q;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_zero  = rsp_zero_q;

    // Structural invariants of the handshake.
    a_rsp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
    a_ready_idle: assert property (@(posedge clk) disable iff (rst)
                                   (state_q != IDLE) |-> (req_ready == 2'b00));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level arbitration model.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;

    logic        clk;
    logic        rst;
    logic [7:0]  req_op;
    logic [63:0] req_in1;
    logic [63:0] req_in2;

    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] rsp_out, alu_in1, alu_in2, alu_out;
    logic        rsp_zero, alu_zero;
    logic [3:0]  alu_op;

    logic [1:0]  fp_req_valid, fp_req_ready, fp_rsp_valid, fp_rsp_ready;
    logic [31:0] fp_rsp_out, fp_alu_in1, fp_alu_in2, fp_alu_out;
    logic        fp_rsp_zero, fp_alu_zero;
    logic [3:0]  fp_alu_op;

    int checks;
    int failures;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return 32'h0;
        endcase
    endfunction

    // Shared ALU instances, one per arbiter.
    assign alu_out     = alu_f(alu_op, alu_in1, alu_in2);
    assign alu_zero    = (alu_out == 32'h0);
    assign fp_alu_out  = alu_f(fp_alu_op, fp_alu_in1, fp_alu_in2);
    assign fp_alu_zero = (fp_alu_out == 32'h0);

    alu_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_zero(rsp_zero),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req_valid(fp_req_valid), .req_ready(fp_req_ready),
        .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready),
        .rsp_out(fp_rsp_out), .rsp_zero(fp_rsp_zero),
        .alu_in1(fp_alu_in1), .alu_in2(fp_alu_in2), .alu_op(fp_alu_op),
        .alu_out(fp_alu_out), .alu_zero(fp_alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_payload(input int unsigned r, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            req_op[3:0]    = op;
            req_in1[31:0]  = a;
            req_in2[31:0]  = b;
        end else begin
            req_op[7:4]    = op;
            req_in1[63:32] = a;
            req_in2[63:32] = b;
        end
    endtask

    // One uncontended transaction on the round-robin instance, started from IDLE.
    task automatic run_single(input string name, input int unsigned r, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_out, input logic exp_zero);
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        set_payload(r, op, a, b);
        req_valid = oh;
        rsp_ready = 2'b11;
        #1;
        check({name, ".accept_ready"}, 32'(req_ready), 32'(oh));
        @(posedge clk); #1;
        req_valid = 2'b00;
        check({name, ".exec_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({name, ".exec_ready"}, 32'(req_ready), 32'h0);
        check({name, ".alu_op"}, 32'(alu_op), 32'(op));
        check({name, ".alu_in1"}, alu_in1, a);
        check({name, ".alu_in2"}, alu_in2, b);
        @(posedge clk); #1;
        check({name, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
        check({name, ".rsp_out"}, rsp_out, exp_out);
        check({name, ".rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
        @(posedge clk); #1;
        check({name, ".rsp_cleared"}, 32'(rsp_valid), 32'h0);
    endtask

    typedef struct {
        int unsigned r;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
    } vec_t;

    vec_t        vecs [6];
    logic [3:0]  rops [4];
    logic [3:0]  fops [3];
    logic [31:0] fa [3];
    logic [31:0] fb [3];
    logic [31:0] fexp [3];
    bit          pres [2];
    bit          m_busy, m_resp, m_owner, m_last;
    logic [31:0] m_res;
    logic [1:0]  exp_g;

    initial begin
        vecs[0] = '{0, OP_ADD, 32'h00000AC3, 32'h0000011F, 32'h00000BE2, 1'b0};
        vecs[1] = '{1, OP_SUB, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1};
        vecs[2] = '{0, OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{1, OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[4] = '{0, OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
        vecs[5] = '{1, OP_SUB, 32'h00000AC3, 32'h0000011F, 32'h000009A4, 1'b0};
        rops = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
        fops = '{OP_ADD, OP_SUB, OP_SUB};
        fa   = '{32'h1, 32'hA, 32'h77};
        fb   = '{32'h2, 32'h4, 32'h77};
        fexp = '{32'h3, 32'h6, 32'h0};
        checks = 0;
        failures = 0;

        rst = 1'b0;
        req_valid = '0; rsp_ready = '0; fp_req_valid = '0; fp_rsp_ready = '0;
        req_op = '0; req_in1 = '0; req_in2 = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values; req_ready already follows the IDLE rule while held in reset.
        check("reset.rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset.rsp_out", rsp_out, 32'h0);
        check("reset.rsp_zero", 32'(rsp_zero), 32'h0);
        check("reset.alu_op", 32'(alu_op), 32'h0);
        check("reset.alu_in1", alu_in1, 32'h0);
        check("reset.alu_in2", alu_in2, 32'h0);
        check("reset.req_ready_idle", 32'(req_ready), 32'h0);
        check("reset.fp_rsp_valid", 32'(fp_rsp_valid), 32'h0);
        req_valid = 2'b11; #1;
        check("reset.req_ready_both", 32'(req_ready), 32'h1);
        req_valid = 2'b10; #1;
        check("reset.req_ready_r1", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        rst = 1'b0;

        // Contention right after reset: requester 0 first, then requester 1.
        set_payload(0, OP_SUB, 32'hAC3, 32'h11F);
        set_payload(1, OP_ADD, 32'h11F, 32'hAC3);
        req_valid = 2'b11; rsp_ready = 2'b11; #1;
        check("cont.ready_first", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b10;
        check("cont.exec_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        check("cont.rsp0_valid", 32'(rsp_valid), 32'h1);
        check("cont.rsp0_out", rsp_out, 32'h000009A4);
        check("cont.rsp0_zero", 32'(rsp_zero), 32'h0);
        @(posedge clk); #1;
        check("cont.idle_rsp", 32'(rsp_valid), 32'h0);
        check("cont.ready_second", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("cont.alu_op1", 32'(alu_op), 32'(OP_ADD));
        check("cont.alu_in1_1", alu_in1, 32'h11F);
        @(posedge clk); #1;
        check("cont.rsp1_valid", 32'(rsp_valid), 32'h2);
        check("cont.rsp1_out", rsp_out, 32'h00000BE2);
        @(posedge clk); #1;
        check("cont.done", 32'(rsp_valid), 32'h0);

        for (int i = 0; i < 6; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b,
                       vecs[i].exp_out, vecs[i].exp_zero);
        end

        // Backpressure: owner withholds rsp_ready while requester 1 waits.
        set_payload(0, OP_ADD, 32'h11111111, 32'h22222222);
        req_valid = 2'b01; rsp_ready = 2'b00; #1;
        check("bp.accept_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        set_payload(1, OP_SUB, 32'h50, 32'h30);
        req_valid = 2'b10;
        for (int i = 0; i < 7; i++) begin
            rsp_ready = (i < 5) ? 2'b00 : 2'b10;
            check($sformatf("bp.hold_valid%0d", i), 32'(rsp_valid), 32'h1);
            check($sformatf("bp.hold_out%0d", i), rsp_out, 32'h33333333);
            check($sformatf("bp.hold_ready%0d", i), 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b01;
        check("bp.still_valid", 32'(rsp_valid), 32'h1);
        @(posedge clk); #1;
        check("bp.released", 32'(rsp_valid), 32'h0);
        check("bp.ready_r1", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("bp.r1_alu_op", 32'(alu_op), 32'(OP_SUB));
        check("bp.r1_alu_in1", alu_in1, 32'h50);
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        check("bp.r1_rsp_valid", 32'(rsp_valid), 32'h2);
        check("bp.r1_rsp_out", rsp_out, 32'h20);
        @(posedge clk); #1;
        check("bp.r1_done", 32'(rsp_valid), 32'h0);

        // Valid withdrawn before any edge: nothing is latched.
        set_payload(0, OP_ADD, 32'h5, 32'h3);
        req_valid = 2'b01; #1;
        check("drop.ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        @(posedge clk); #1;
        check("drop.alu_op_held", 32'(alu_op), 32'(OP_SUB));
        check("drop.alu_in1_held", alu_in1, 32'h50);
        @(posedge clk); #1;
        check("drop.no_rsp", 32'(rsp_valid), 32'h0);
        run_single("after_drop", 1, OP_ADD, 32'hDEAD0000, 32'h0000BEEF, 32'hDEADBEEF, 1'b0);

        // Reset pulse during EXEC drops the operation immediately.
        set_payload(1, OP_SUB, 32'h99, 32'h11);
        req_valid = 2'b10; rsp_ready = 2'b11; #1;
        check("rexec.accept_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("rexec.alu_op_pre", 32'(alu_op), 32'(OP_SUB));
        rst = 1'b1; #1;
        check("rexec.rsp_valid", 32'(rsp_valid), 32'h0);
        check("rexec.alu_op", 32'(alu_op), 32'h0);
        check("rexec.alu_in1", alu_in1, 32'h0);
        check("rexec.alu_in2", alu_in2, 32'h0);
        check("rexec.rsp_out", rsp_out, 32'h0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rexec.no_rsp%0d", i), 32'(rsp_valid), 32'h0);
        end
        req_valid = 2'b11; #1;
        check("rexec.ptr_reset", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        run_single("after_reset", 0, OP_SUB, 32'h100, 32'h1, 32'hFF, 1'b0);

        // Randomized run against a transaction-level model.
        @(negedge clk);
        rst = 1'b1; #1 rst = 1'b0;
        pres[0] = 1'b0; pres[1] = 1'b0;
        m_busy = 1'b0; m_resp = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_res = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!pres[r] && $urandom_range(0, 2) == 0) begin
                    pres[r] = 1'b1;
                    set_payload(r, rops[$urandom_range(0, 3)], $urandom, $urandom);
                end
            end
            req_valid = {pres[1], pres[0]};
            rsp_ready = 2'($urandom);
            #1;
            exp_g = 2'b00;
            if (!m_busy) begin
                if (pres[0] && pres[1]) exp_g = m_last ? 2'b01 : 2'b10;
                else                    exp_g = {pres[1], pres[0]};
            end
            check($sformatf("rand%0d.req_ready", cyc), 32'(req_ready), 32'(exp_g));
            check($sformatf("rand%0d.rsp_valid", cyc), 32'(rsp_valid),
                  m_resp ? (m_owner ? 32'h2 : 32'h1) : 32'h0);
            if (m_resp) begin
                check($sformatf("rand%0d.rsp_out", cyc), rsp_out, m_res);
                check($sformatf("rand%0d.rsp_zero", cyc), 32'(rsp_zero), 32'(m_res == 32'h0));
            end
            // Outcome of the coming edge: grant, one compute cycle, then wait for owner.
            if (!m_busy) begin
                if (exp_g != 2'b00) begin
                    m_owner = exp_g[1];
                    m_last  = exp_g[1];
                    m_res   = m_owner ? alu_f(req_op[7:4], req_in1[63:32], req_in2[63:32])
                                      : alu_f(req_op[3:0], req_in1[31:0], req_in2[31:0]);
                    m_busy  = 1'b1;
                    m_resp  = 1'b0;
                    pres[m_owner] = 1'b0;
                end
            end else if (!m_resp) begin
                m_resp = 1'b1;
            end else if (rsp_ready[m_owner]) begin
                m_busy = 1'b0;
                m_resp = 1'b0;
            end
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;

        // Fixed-priority instance: requester 0 keeps winning while it stays valid.
        @(negedge clk);
        set_payload(1, OP_ADD, 32'h1000, 32'h0234);
        fp_req_valid = 2'b11; fp_rsp_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            set_payload(0, fops[k], fa[k], fb[k]);
            #1;
            check($sformatf("fp%0d.ready", k), 32'(fp_req_ready), 32'h1);
            @(posedge clk); #1;
            check($sformatf("fp%0d.exec_ready", k), 32'(fp_req_ready), 32'h0);
            @(posedge clk); #1;
            check($sformatf("fp%0d.rsp_valid", k), 32'(fp_rsp_valid), 32'h1);
            check($sformatf("fp%0d.rsp_out", k), fp_rsp_out, fexp[k]);
            check($sformatf("fp%0d.rsp_zero", k), 32'(fp_rsp_zero), 32'(fexp[k] == 32'h0));
            @(posedge clk); #1;
        end
        fp_req_valid = 2'b10; #1;
        check("fp.ready_r1", 32'(fp_req_ready), 32'h2);
        @(posedge clk); #1;
        fp_req_valid = 2'b00;
        @(posedge clk); #1;
        check("fp.r1_rsp_valid", 32'(fp_rsp_valid), 32'h2);
        check("fp.r1_rsp_out", fp_rsp_out, 32'h1234);
        @(posedge clk); #1;
        check("fp.r1_done", 32'(fp_rsp_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock only.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester request valid, bit n = requester n.
REQ-005 req_ready  output  2  per-requester request accept.
REQ-006 req_op  input  8  packed ALU opcodes, {op1[3:0], op0[3:0]}.
REQ-007 req_in1  input  64  packed first operands, {in1_1, in1_0}.
REQ-008 req_in2  input  64  packed second operands, {in2_1, in2_0}.
REQ-009 rsp_valid  output  2  result valid, one-hot to the owning requester.
REQ-010 rsp_ready  input  2  per-requester result accept.
REQ-011 rsp_out  output  32  captured ALU result.
REQ-012 rsp_zero  output  1  captured ALU zero flag.
REQ-013 alu_in1, alu_in2  output  32 each  operands to the shared alu instance.
REQ-014 alu_op  output  4  opcode to the shared alu instance.
REQ-015 alu_out  input  32, and alu_zero  input  1: results from the shared alu instance.

Function
REQ-016 The block SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-017 In IDLE, the block SHALL assert req_ready only on the one-hot grant, computed combinationally from req_valid; req_ready SHALL be 00 in EXEC and RESP.
REQ-018 A transfer SHALL occur when req_valid[g] and req_ready[g] are both high at a clk edge: the block latches op, in1 and in2 of requester g into operand registers, records owner = g, and goes IDLE->EXEC.
REQ-019 alu_op, alu_in1 and alu_in2 SHALL be driven only from the operand registers, so they are stable for the whole EXEC cycle and hold their last values otherwise.
REQ-020 At the EXEC-ending edge, the block SHALL capture alu_out and alu_zero into rsp_out and rsp_zero and go EXEC->RESP.
REQ-021 Latency: rsp_valid[owner] SHALL rise exactly one cycle after the accepting edge; minimum throughput is one operation per 3 cycles.
REQ-022 In RESP, rsp_valid SHALL equal the owner one-hot; at an edge with rsp_ready[owner]=1, the FSM goes RESP->IDLE. rsp_ready of the non-owner SHALL be ignored.
REQ-023 rsp_out and rsp_zero SHALL hold their values until the next capture.
REQ-024 Only a single valid requester present: that requester SHALL be granted, regardless of RR_EN.
REQ-025 Both requesters valid with RR_EN=1: the block SHALL grant the requester not granted last; the last-grant pointer updates on each transfer.
REQ-026 Both requesters valid with RR_EN=0: requester 0 SHALL be granted.
REQ-027 A requester holds valid and payload until ready; if valid drops before the handshake, the block SHALL take no action and no state change.
REQ-028 New requests arriving during EXEC or RESP SHALL wait, with none lost or reordered per requester.

Reset
REQ-029 Asserting rst SHALL immediately force, in any state: state=IDLE, rsp_valid=00, rsp_out=0, rsp_zero=0, operand registers=0 (alu_op=0000, alu_in1=0, alu_in2=0), owner=0, and the last-grant pointer=1 (so requester 0 wins first). req_ready SHALL then follow the IDLE rule.
REQ-030 An operation in flight when reset is asserted SHALL be dropped without a response.

Verification (opcodes: ADD=4'b0000, SUB=4'b1000; bench instantiates alu with the block)
REQ-031 Single request: req0 ADD 0x00000AC3 + 0x0000011F, rsp_ready=11 -> req_ready=01 in the accept cycle; rsp_valid=01 one cycle later; rsp_out=0x00000BE2, rsp_zero=0.
REQ-032 Contention, RR_EN=1, first cycle after reset: req0 SUB 0xAC3 - 0x11F and req1 ADD 0x11F + 0xAC3 -> req0 is served first with rsp_out=0x000009A4; then req1 is served with rsp_valid=10 and rsp_out=0x00000BE2.
REQ-033 Backpressure: rsp_ready=00 for 5 cycles while req1 is valid -> rsp_valid and rsp_out are stable, and req_ready=00 throughout; then rsp_ready[owner]=1 -> IDLE, and req1 is accepted on the next edge.
REQ-034 Zero flag: req1 SUB 0x12345678 - 0x12345678 -> rsp_out=0x00000000, rsp_zero=1.
REQ-035 Reset during EXEC: pulse rst -> rsp_valid=00 and alu_op=0000 without waiting for a clock edge; no response for the dropped operation; the next request completes normally.
REQ-036 RR_EN=0, both requesters valid for three operations -> requester 0 is granted all three; requester 1 is granted only after req_valid[0] drops.
